// File: rtl/pipe_flow_ctrl_if.sv
// Signal bundle between the pipeline stages and the flow controller.
// The controller holds the master modport. The pipeline side holds the slave modport.
interface pipe_flow_ctrl_if #(
    parameter int NSTAGE = 6,
    parameter int XLEN   = 32,
    parameter int CNTW   = 32
);
    // No valid/ready pairs here. Every field is sampled or driven every cycle.
    logic [NSTAGE-1:0] stall_req;
    logic [XLEN-1:0]   except_type;
    logic [XLEN-1:0]   cp0_epc;
    logic [NSTAGE-1:0] stall_ctrl;
    logic              flush;
    logic              pc_redirect;
    logic [XLEN-1:0]   pc_new;
    logic              stall_timeout;
    logic [CNTW-1:0]   stall_cnt;

    modport master (
        input  stall_req, except_type, cp0_epc,
        output stall_ctrl, flush, pc_redirect, pc_new, stall_timeout, stall_cnt
    );

    modport slave (
        output stall_req, except_type, cp0_epc,
        input  stall_ctrl, flush, pc_redirect, pc_new, stall_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller. It merges stall requests, sequences exception flushes
// and PC redirects, and keeps a stall watchdog and a stall performance counter.
module pipe_flow_ctrl #(
    parameter int                NSTAGE    = 6,
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   INT_VEC   = 32'h00000020,
    parameter logic [XLEN-1:0]   EXC_VEC   = 32'h00000040,
    parameter int                FLUSH_CYC = 1,
    parameter int                STALL_TMO = 1023,
    parameter int                CNTW      = 32,
    localparam int               WDW       = $clog2(STALL_TMO + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_flow_ctrl_if.master     bus,
    output logic                 dbg_state,
    output logic [WDW-1:0]       dbg_wdog
);
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [3:0]     FCYC = 4'(FLUSH_CYC);
    localparam logic [WDW-1:0] TMO  = WDW'(STALL_TMO);

    state_t            state, state_nxt;
    logic [3:0]        flush_cnt, cnt_nxt;
    logic [XLEN-1:0]   vec_q, vec_nxt;
    logic [WDW-1:0]    wdog, wdog_nxt;
    logic              timeout_q;
    logic [CNTW-1:0]   cnt_q;
    logic [NSTAGE-1:0] therm, stall_ctrl;
    logic              except_hit, stall_active, redirect;

    // Codes 0x8/0xa/0xc/0xd fall into EXC_VEC together with every other unlisted code.
    function automatic logic [XLEN-1:0] map_vec(input logic [XLEN-1:0] code,
                                                input logic [XLEN-1:0] epc);
        if (code == XLEN'(1))       return INT_VEC;
        else if (code == XLEN'(14)) return epc;
        else                        return EXC_VEC;
    endfunction

    always_comb begin
        therm = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            therm[i] = (i == NSTAGE - 1) ? bus.stall_req[i] : (bus.stall_req[i] | therm[i+1]);
        end
    end

    assign except_hit   = (bus.except_type != '0);
    assign stall_ctrl   = (!rst && state == IDLE && !except_hit) ? therm : '0;
    assign stall_active = (stall_ctrl != '0);
    assign redirect     = !rst && state == FLUSH && flush_cnt == FCYC;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = flush_cnt;
        vec_nxt   = vec_q;
        case (state)
            IDLE: begin
                if (except_hit) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FCYC;
                    vec_nxt   = map_vec(bus.except_type, bus.cp0_epc);
                end
            end
            FLUSH: begin
                cnt_nxt = flush_cnt - 4'd1;
                if (flush_cnt == 4'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wdog_nxt = '0;
        if (stall_active) wdog_nxt = (wdog == TMO) ? wdog : wdog + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            vec_q     <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= cnt_nxt;
            vec_q     <= vec_nxt;
            wdog      <= wdog_nxt;
            if (wdog_nxt == TMO) timeout_q <= 1'b1;
            if (stall_active)    cnt_q     <= cnt_q + 1'b1;
        end
    end

    assign bus.stall_ctrl    = stall_ctrl;
    assign bus.flush         = !rst && state == FLUSH;
    assign bus.pc_redirect   = redirect;
    assign bus.pc_new        = redirect ? vec_q : '0;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cnt     = cnt_q;
    assign dbg_state         = state;
    assign dbg_wdog          = wdog;
endmodule
